// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified instruction/data memory between the
// CPU core and the debug/loader port. Each access is one strobe, a fixed
// read-latency wait, and a one-cycle ack. Round-robin arbitration, with
// dbg_hold keeping the CPU off the memory. All outputs are registered.
module mem_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_hold,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [2:0]        cnt_r;
    logic              last_r;       // 1 = debug owned the previous access
    logic              owner_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              mem_re_r;
    logic              mem_we_r;
    logic              cpu_ack_r;
    logic              dbg_ack_r;
    logic              busy_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] dbg_rdata_r;

    logic              cpu_elig_s;
    logic              dbg_elig_s;
    logic              grant_s;
    logic              grant_dbg_s;
    logic              cnt_last_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // Next-state logic and round-robin grant decision.
    always_comb begin
        state_s     = state_r;
        grant_s     = 1'b0;
        grant_dbg_s = 1'b0;
        cpu_elig_s  = cpu_req & ~dbg_hold;
        dbg_elig_s  = dbg_req;
        cnt_last_s  = (cnt_r == 3'd1);
        case (state_r)
            IDLE: begin
                if (cpu_elig_s && dbg_elig_s) begin
                    // Tie: the requester that did not own the last access wins.
                    grant_s     = 1'b1;
                    grant_dbg_s = ~last_r;
                end else if (dbg_elig_s) begin
                    grant_s     = 1'b1;
                    grant_dbg_s = 1'b1;
                end else if (cpu_elig_s) begin
                    grant_s     = 1'b1;
                    grant_dbg_s = 1'b0;
                end else begin
                    grant_s     = 1'b0;
                    grant_dbg_s = 1'b0;
                end
                if (grant_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (we_r) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Request mux feeding the grant-time capture registers.
    always_comb begin
        sel_we_s    = cpu_we;
        sel_addr_s  = cpu_addr;
        sel_wdata_s = cpu_wdata;
        if (grant_dbg_s) begin
            sel_we_s    = dbg_we;
            sel_addr_s  = dbg_addr;
            sel_wdata_s = dbg_wdata;
        end else begin
            sel_we_s    = cpu_we;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture the winner's command at the grant edge; it is not re-sampled later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r <= 1'b0;
            last_r  <= 1'b1;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (grant_s) begin
            owner_r <= grant_dbg_s;
            last_r  <= grant_dbg_s;
            we_r    <= sel_we_s;
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
        end
    end

    // Strobes, acks and busy are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_re_r  <= 1'b0;
            mem_we_r  <= 1'b0;
            cpu_ack_r <= 1'b0;
            dbg_ack_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            mem_re_r  <= grant_s & ~sel_we_s;
            mem_we_r  <= grant_s & sel_we_s;
            cpu_ack_r <= (state_s == DONE) & ~owner_r;
            dbg_ack_r <= (state_s == DONE) & owner_r;
            busy_r    <= (state_s != IDLE);
        end
    end

    // Read-latency down-counter: loaded in ISSUE, last WAIT cycle is cnt==1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 3'd0;
        end else if (state_r == ISSUE) begin
            cnt_r <= 3'(RD_LAT);
        end else if ((state_r == WAIT) && !cnt_last_s) begin
            cnt_r <= cnt_r - 3'd1;
        end
    end

    // Memory read data lands in the owner's register only; the other holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata_r <= '0;
            dbg_rdata_r <= '0;
        end else if ((state_r == WAIT) && cnt_last_s) begin
            if (owner_r) begin
                dbg_rdata_r <= mem_rdata;
            end else begin
                cpu_rdata_r <= mem_rdata;
            end
        end
    end

    assign cpu_ack   = cpu_ack_r;
    assign dbg_ack   = dbg_ack_r;
    assign cpu_rdata = cpu_rdata_r;
    assign dbg_rdata = dbg_rdata_r;
    assign mem_re    = mem_re_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign busy      = busy_r;
    assign owner     = owner_r;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares the single unified instruction/data memory between two requesters: the multi-cycle CPU core and a debug/loader port driven from the board switches. Each access runs through a small FSM that issues exactly one memory strobe, waits out the memory's fixed read latency, and returns data with a one-cycle ack pulse. Arbitration is round-robin, and a debug freeze input holds the CPU off the memory. The block sits between the core/debug logic and the memory macro.

Parameters:
ADDR_W, 9, word address width (byte address bits [10:2])
DATA_W, 32, data width
RD_LAT, 1, memory read latency in cycles from strobe to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid with cpu_ack, held until the next CPU read ack
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  same as the cpu_* ports, for the debug port
dbg_hold  in  1  1 = CPU ineligible for grant
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  1 when the FSM is not in IDLE
owner  out  1  0=CPU, 1=debug; meaningful only while busy=1

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; the last-owner flag resets to debug, so the CPU wins the first tie. All outputs are 0, including both rdata registers and mem_addr/mem_wdata.
- States: IDLE, ISSUE, WAIT, DONE. Cycle numbering below starts at 0, the IDLE cycle in which the grant is sampled.
- IDLE: eligible set = {dbg if dbg_req} plus {cpu if cpu_req and !dbg_hold}.
  - One eligible requester: grant it.
  - Two: grant the one that is not the last owner.
  - None: stay in IDLE.
  - On grant: register the requester's we, addr and wdata, set owner, update last-owner, go to ISSUE.
- ISSUE (cycle 1): mem_re=!we or mem_we=we for exactly this cycle; mem_addr and mem_wdata come from the registered values.
  - Write: go to DONE.
  - Read: go to WAIT and load the counter with RD_LAT.
- WAIT: stay for RD_LAT cycles (cycles 2..RD_LAT+1). At the edge ending the last WAIT cycle, capture mem_rdata into the owner's rdata register, then go to DONE.
- DONE: the owner's ack=1 for one cycle; requests are ignored in this cycle; next state is IDLE.
- Latency from req sampled to ack: read = RD_LAT+2 cycles (3 at default); write = 2 cycles. Back-to-back throughput: one read per RD_LAT+3 cycles, one write per 3 cycles.
- mem_addr and mem_wdata hold their registered values from ISSUE until the next grant. Strobes are 0 in every state except ISSUE. At most one of mem_re/mem_we is high in any cycle.
- Only the owner's ack or rdata changes. The other port's rdata holds its value.
- addr, we and wdata are sampled only at the grant edge; later changes do not affect the access in progress.
- If req drops before ack, the access still completes and ack still pulses.
- dbg_hold rising during a CPU access: that access completes normally; further CPU requests wait until dbg_hold=0. dbg_hold has no effect on debug requests.
- Reset asserted mid-access: the FSM returns to IDLE immediately and no ack is produced. An in-flight access is lost and the requester must re-issue it; for a write asserted-reset during ISSUE, the memory contents at that address are undefined.
- The WAIT counter is 3 bits wide and counts down to 1; no other arithmetic is performed.

Test Plan:
1. Hold rst=0 mid-simulation with requests active -> all outputs 0 and busy=0 asynchronously; release with no requests -> stays in IDLE, no strobes.
2. CPU read addr 0x010, memory model returns 0xDEADBEEF at RD_LAT=1 -> mem_re=1 and mem_addr=0x010 in cycle 1 only; cpu_ack=1 in cycle 3 with cpu_rdata=0xDEADBEEF; dbg_rdata unchanged.
3. Debug write addr 0x1FF data 0x12345678 -> mem_we=1 in cycle 1 with mem_wdata=0x12345678; dbg_ack in cycle 2; a following CPU read of 0x1FF returns 0x12345678.
4. cpu_req and dbg_req held high continuously with reads -> grant order CPU, DBG, CPU, DBG; acks spaced 4 cycles apart at RD_LAT=1; owner toggles accordingly.
5. dbg_hold=1 with cpu_req held and 3 debug reads -> 3 dbg_acks and no cpu_ack; drop dbg_hold -> CPU granted at the next IDLE, cpu_ack 3 cycles later.
6. rst=0 pulsed during WAIT of a CPU read at RD_LAT=4 -> no cpu_ack; after release a re-issued read completes in 6 cycles with correct data.
